rgen_address_decoder_array: RTL and testbench
=============================================

Name: rgen_address_decoder_array

Overview:
- Multi-register successor to the single-window address decoder. It decodes one host command against REGISTERS independent address windows, each with its own read/write permission.
- Registers the decode result, drives a one-hot select for a programmable number of access cycles, then returns a held response with a decode/permission error flag.
- Sits between the host bus adapter and the register array of a generated register block.

Parameters:
- ADDRESS_WIDTH, 16: width of i_address and of each window bound.
- REGISTERS, 4: number of windows / select lines, >=1.
- START_ADDRESSES, {REGISTERS{16'h0000}}: packed REGISTERS*ADDRESS_WIDTH; slice i is window i's inclusive start.
- END_ADDRESSES, {REGISTERS{16'h0003}}: packed REGISTERS*ADDRESS_WIDTH; slice i is window i's inclusive end; END_i >= START_i.
- READABLE, {REGISTERS{1'b1}}: bit i set means window i accepts reads.
- WRITABLE, {REGISTERS{1'b1}}: bit i set means window i accepts writes.
- WAIT_CYCLES, 0: extra select cycles beyond the first, 0..255.

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  asynchronous active-low reset
- i_command_valid  input  1  host command present
- o_command_ready  output  1  block accepts a command (IDLE only)
- i_address  input  ADDRESS_WIDTH  byte address, sampled at command handshake
- i_read  input  1  read command, sampled at handshake
- i_write  input  1  write command, sampled at handshake
- o_select  output  REGISTERS  one-hot register select, registered
- o_read  output  1  captured read direction, valid while o_select != 0
- o_write  output  1  captured write direction, valid while o_select != 0
- o_response_valid  output  1  response present
- i_response_ready  input  1  host consumes response
- o_error  output  1  response carries error, valid with o_response_valid
- o_index  output  max(1,$clog2(REGISTERS))  matched window index, valid with o_response_valid; 0 on error

Behaviour:
- One clock, i_clk. Reset is asynchronous on the falling edge of i_rst_n and released synchronously to i_clk.
- Reset values:
  - state = IDLE
  - o_select = 0, o_read = 0, o_write = 0
  - o_response_valid = 0, o_error = 0, o_index = 0
  - wait counter = 0
- o_command_ready = (state==IDLE), decoded combinationally; it reads 1 during reset. Commands are ignored while i_rst_n is low.
- Window match i: START_i <= i_address <= END_i, unsigned, full ADDRESS_WIDTH compare. No alignment requirement.
- Overlap: the lowest matching index wins, so o_select is always one-hot or zero.
- Permission failure: the winning window lacks the requested direction, i.e. (i_read && !READABLE[i]) or (i_write && !WRITABLE[i]).
- Error is captured at handshake when any of these holds:
  - no window matches
  - permission failure
  - i_read == i_write (both or neither)
- FSM states: IDLE, ACCESS, RESPONSE.
  - IDLE: on i_command_valid && o_command_ready, capture address/direction decode and go to ACCESS next cycle.
  - ACCESS:
    - o_select = one-hot of the winner, or 0 if error. o_read/o_write = captured direction, both 0 if error.
    - Stays exactly WAIT_CYCLES+1 cycles, counted by the wait counter of width max(1,$clog2(WAIT_CYCLES+1)).
    - Then goes to RESPONSE. o_select, o_read and o_write fall to 0 on entry to RESPONSE.
  - RESPONSE:
    - o_response_valid = 1 with o_error/o_index held stable until i_response_ready.
    - On i_response_ready, go to IDLE next cycle; o_response_valid = 0 in that cycle.
- Throughput: handshake at T, select T+1..T+1+WAIT_CYCLES, response from T+2+WAIT_CYCLES. With immediate ready, the next command can be accepted at T+3+WAIT_CYCLES.
- i_response_ready outside RESPONSE is ignored. Inputs other than i_response_ready are ignored outside IDLE.
- Reset asserted mid-ACCESS or mid-RESPONSE: all outputs go to reset values immediately, and the in-flight command is dropped with no response.
- An error command still spends the full ACCESS duration, with o_select = 0, so latency is independent of decode result.

Test Plan:
- Reset release, REGISTERS=4, windows 0x00-03/0x04-07/0x08-0B/0x10-1F, WAIT_CYCLES=0 -> o_command_ready=1; o_select, o_response_valid and o_error all 0.
- Read 0x06 at T, response_ready held 1 -> o_select=4'b0010 and o_read=1 at T+1 only; o_response_valid=1, o_error=0, o_index=1 at T+2; idle at T+3.
- Write 0x0C (gap between windows) -> o_select=0 during ACCESS; response o_error=1, o_index=0.
- WRITABLE[3]=0, write 0x15 -> o_select stays 0 and the response shows o_error=1. Read 0x15 -> o_select=4'b1000, o_error=0, o_index=3.
- WAIT_CYCLES=3, read 0x00, response_ready low for 5 cycles -> o_select=4'b0001 for exactly 4 cycles. Response held 5 cycles with stable fields; i_command_valid is not accepted during that time.
- Overlapping windows 0x00-0F and 0x08-0B, read 0x09 -> o_index=0. Separately: i_rst_n low in the 2nd ACCESS cycle -> o_select=0 immediately and no response after release.

Source files
------------

// File: rtl/rgen_address_decoder_array.sv
// rtl/rgen_address_decoder_array.sv - multi-window host command decoder with timed select and held response
module rgen_address_decoder_array #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int REGISTERS = 4,
    parameter logic [REGISTERS*ADDRESS_WIDTH-1:0] START_ADDRESSES = {REGISTERS{16'h0000}},
    parameter logic [REGISTERS*ADDRESS_WIDTH-1:0] END_ADDRESSES = {REGISTERS{16'h0003}},
    parameter logic [REGISTERS-1:0] READABLE = {REGISTERS{1'b1}},
    parameter logic [REGISTERS-1:0] WRITABLE = {REGISTERS{1'b1}},
    parameter int WAIT_CYCLES = 0,
    localparam int INDEX_WIDTH = (REGISTERS > 1) ? $clog2(REGISTERS) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_command_valid,
    output logic                     o_command_ready,
    input  logic [ADDRESS_WIDTH-1:0] i_address,
    input  logic                     i_read,
    input  logic                     i_write,
    output logic [REGISTERS-1:0]     o_select,
    output logic                     o_read,
    output logic                     o_write,
    output logic                     o_response_valid,
    input  logic                     i_response_ready,
    output logic                     o_error,
    output logic [INDEX_WIDTH-1:0]   o_index
);

    localparam int COUNT_WIDTH = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [COUNT_WIDTH-1:0] COUNT_LAST = COUNT_WIDTH'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        RESPONSE = 2'd2
    } state_t;

    state_t                   state_q;
    logic [COUNT_WIDTH-1:0]   count_q;
    logic [REGISTERS-1:0]     select_q;
    logic                     read_q;
    logic                     write_q;
    logic                     response_valid_q;
    logic                     error_q;
    logic [INDEX_WIDTH-1:0]   index_q;
    // Decode result captured at handshake, published only when the response is raised
    logic                     pending_error_q;
    logic [INDEX_WIDTH-1:0]   pending_index_q;

    logic                     hit_d;
    logic                     hit_readable_d;
    logic                     hit_writable_d;
    logic [INDEX_WIDTH-1:0]   hit_index_d;
    logic [REGISTERS-1:0]     hit_onehot_d;
    logic                     error_d;

    assign o_command_ready  = (state_q == IDLE);
    assign o_select         = select_q;
    assign o_read           = read_q;
    assign o_write          = write_q;
    assign o_response_valid = response_valid_q;
    assign o_error          = error_q;
    assign o_index          = index_q;

    // Window match with lowest-index priority: scan downward so the lowest hit is written last
    always_comb begin
        hit_d          = 1'b0;
        hit_readable_d = 1'b0;
        hit_writable_d = 1'b0;
        hit_index_d    = '0;
        hit_onehot_d   = '0;
        for (int i = REGISTERS - 1; i >= 0; i--) begin
            if ((i_address >= START_ADDRESSES[i*ADDRESS_WIDTH +: ADDRESS_WIDTH]) &&
                (i_address <= END_ADDRESSES[i*ADDRESS_WIDTH +: ADDRESS_WIDTH])) begin
                hit_d          = 1'b1;
                hit_readable_d = READABLE[i];
                hit_writable_d = WRITABLE[i];
                hit_index_d    = INDEX_WIDTH'(i);
                hit_onehot_d   = '0;
                hit_onehot_d[i] = 1'b1;
            end
        end
        error_d = !hit_d
                  || (i_read && !hit_readable_d)
                  || (i_write && !hit_writable_d)
                  || (i_read == i_write);
    end

    // Command sequencer: capture in IDLE, hold select for WAIT_CYCLES+1 cycles, then hold the response
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q          <= IDLE;
            count_q          <= '0;
            select_q         <= '0;
            read_q           <= 1'b0;
            write_q          <= 1'b0;
            response_valid_q <= 1'b0;
            error_q          <= 1'b0;
            index_q          <= '0;
            pending_error_q  <= 1'b0;
            pending_index_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_command_valid) begin
                        state_q         <= ACCESS;
                        count_q         <= '0;
                        select_q        <= error_d ? '0 : hit_onehot_d;
                        read_q          <= error_d ? 1'b0 : i_read;
                        write_q         <= error_d ? 1'b0 : i_write;
                        pending_error_q <= error_d;
                        pending_index_q <= error_d ? '0 : hit_index_d;
                    end
                end
                ACCESS: begin
                    if (count_q == COUNT_LAST) begin
                        state_q          <= RESPONSE;
                        count_q          <= '0;
                        select_q         <= '0;
                        read_q           <= 1'b0;
                        write_q          <= 1'b0;
                        response_valid_q <= 1'b1;
                        error_q          <= pending_error_q;
                        index_q          <= pending_index_q;
                    end else begin
                        count_q <= count_q + COUNT_WIDTH'(1);
                    end
                end
                RESPONSE: begin
                    if (i_response_ready) begin
                        state_q          <= IDLE;
                        response_valid_q <= 1'b0;
                        error_q          <= 1'b0;
                        index_q          <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rgen_address_decoder_array.sv
// tb/tb_rgen_address_decoder_array.sv - directed self-checking bench for rgen_address_decoder_array
module tb_rgen_address_decoder_array;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected responses {error, index}, pushed when a command is driven
    logic [2:0] exp_q[$];

    logic rst_n  = 1'b0;
    logic rst2_n = 1'b0;

    // d0: four windows, WAIT_CYCLES=0, window 3 not writable
    logic        v0 = 0, r0 = 0, w0 = 0, rr0 = 0;
    logic [15:0] a0 = '0;
    logic        cr0, or0, ow0, rv0, er0;
    logic [3:0]  sel0;
    logic [1:0]  idx0;

    // d1: same windows, WAIT_CYCLES=3
    logic        v1 = 0, r1 = 0, w1 = 0, rr1 = 0;
    logic [15:0] a1 = '0;
    logic        cr1, or1, ow1, rv1, er1;
    logic [3:0]  sel1;
    logic [1:0]  idx1;

    // d2: overlapping windows, WAIT_CYCLES=1
    logic        v2 = 0, r2 = 0, w2 = 0, rr2 = 0;
    logic [15:0] a2 = '0;
    logic        cr2, or2, ow2, rv2, er2;
    logic [3:0]  sel2;
    logic [1:0]  idx2;

    rgen_address_decoder_array #(
        .ADDRESS_WIDTH(16), .REGISTERS(4),
        .START_ADDRESSES({16'h0010, 16'h0008, 16'h0004, 16'h0000}),
        .END_ADDRESSES  ({16'h001F, 16'h000B, 16'h0007, 16'h0003}),
        .READABLE(4'b1111), .WRITABLE(4'b0111), .WAIT_CYCLES(0)
    ) d0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_command_valid(v0), .o_command_ready(cr0),
        .i_address(a0), .i_read(r0), .i_write(w0), .o_select(sel0), .o_read(or0),
        .o_write(ow0), .o_response_valid(rv0), .i_response_ready(rr0),
        .o_error(er0), .o_index(idx0)
    );

    rgen_address_decoder_array #(
        .ADDRESS_WIDTH(16), .REGISTERS(4),
        .START_ADDRESSES({16'h0010, 16'h0008, 16'h0004, 16'h0000}),
        .END_ADDRESSES  ({16'h001F, 16'h000B, 16'h0007, 16'h0003}),
        .READABLE(4'b1111), .WRITABLE(4'b1111), .WAIT_CYCLES(3)
    ) d1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_command_valid(v1), .o_command_ready(cr1),
        .i_address(a1), .i_read(r1), .i_write(w1), .o_select(sel1), .o_read(or1),
        .o_write(ow1), .o_response_valid(rv1), .i_response_ready(rr1),
        .o_error(er1), .o_index(idx1)
    );

    rgen_address_decoder_array #(
        .ADDRESS_WIDTH(16), .REGISTERS(4),
        .START_ADDRESSES({16'h0030, 16'h0020, 16'h0008, 16'h0000}),
        .END_ADDRESSES  ({16'h003F, 16'h002F, 16'h000B, 16'h000F}),
        .READABLE(4'b1111), .WRITABLE(4'b1111), .WAIT_CYCLES(1)
    ) d2 (
        .i_clk(clk), .i_rst_n(rst2_n), .i_command_valid(v2), .o_command_ready(cr2),
        .i_address(a2), .i_read(r2), .i_write(w2), .o_select(sel2), .o_read(or2),
        .o_write(ow2), .o_response_valid(rv2), .i_response_ready(rr2),
        .o_error(er2), .o_index(idx2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One d0 command with response ready held high: select at T+1 only, response at T+2, idle at T+3
    task automatic d0_cmd(input string tag, input logic [15:0] addr, input logic rd, input logic wr,
                          input logic [3:0] exp_sel, input logic exp_err, input logic [1:0] exp_idx);
        logic [2:0] e;
        chk({tag, "_ready"}, 32'(cr0), 32'd1);
        a0 = addr; r0 = rd; w0 = wr; v0 = 1'b1; rr0 = 1'b1;
        exp_q.push_back({exp_err, exp_idx});
        step();
        v0 = 1'b0; a0 = 16'hFFFF; r0 = 1'b0; w0 = 1'b0;
        chk({tag, "_sel"}, 32'(sel0), 32'(exp_sel));
        chk({tag, "_rd"}, 32'(or0), 32'(exp_err ? 1'b0 : rd));
        chk({tag, "_wr"}, 32'(ow0), 32'(exp_err ? 1'b0 : wr));
        chk({tag, "_busy"}, 32'(cr0), 32'd0);
        step();
        chk({tag, "_sel_off"}, 32'(sel0), 32'd0);
        chk({tag, "_rv"}, 32'(rv0), 32'd1);
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_err"}, 32'(er0), 32'(e[2]));
            chk({tag, "_idx"}, 32'(idx0), 32'(e[1:0]));
        end
        step();
        chk({tag, "_rv_done"}, 32'(rv0), 32'd0);
        chk({tag, "_idle"}, 32'(cr0), 32'd1);
    endtask

    initial begin
        logic [2:0] e;

        // Reset: ready reads 1 even while reset is held, outputs at reset values
        step();
        step();
        chk("rst_ready_during", 32'(cr0), 32'd1);
        chk("rst_sel_during", 32'(sel0), 32'd0);
        rst_n = 1'b1;
        rst2_n = 1'b1;
        step();
        chk("rst_ready", 32'(cr0), 32'd1);
        chk("rst_sel", 32'(sel0), 32'd0);
        chk("rst_rv", 32'(rv0), 32'd0);
        chk("rst_err", 32'(er0), 32'd0);
        chk("rst_idx", 32'(idx0), 32'd0);

        // Directed commands on d0
        d0_cmd("rd06",   16'h0006, 1, 0, 4'b0010, 1'b0, 2'd1);
        d0_cmd("wr0c",   16'h000C, 0, 1, 4'b0000, 1'b1, 2'd0);
        d0_cmd("wr15",   16'h0015, 0, 1, 4'b0000, 1'b1, 2'd0);
        d0_cmd("rd15",   16'h0015, 1, 0, 4'b1000, 1'b0, 2'd3);
        d0_cmd("wr0b",   16'h000B, 0, 1, 4'b0100, 1'b0, 2'd2);
        d0_cmd("rd00",   16'h0000, 1, 0, 4'b0001, 1'b0, 2'd0);
        d0_cmd("both01", 16'h0001, 1, 1, 4'b0000, 1'b1, 2'd0);
        d0_cmd("none01", 16'h0001, 0, 0, 4'b0000, 1'b1, 2'd0);
        d0_cmd("rd1f",   16'h001F, 1, 0, 4'b1000, 1'b0, 2'd3);
        d0_cmd("rd20",   16'h0020, 1, 0, 4'b0000, 1'b1, 2'd0);

        // d1: four select cycles, response held while ready is low, commands refused meanwhile
        a1 = 16'h0000; r1 = 1'b1; w1 = 1'b0; v1 = 1'b1; rr1 = 1'b0;
        exp_q.push_back({1'b0, 2'd0});
        step();
        a1 = 16'h0006;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("w3_sel_c%0d", i), 32'(sel1), 32'h1);
            chk($sformatf("w3_rv_c%0d", i), 32'(rv1), 32'd0);
            step();
        end
        chk("w3_sel_end", 32'(sel1), 32'd0);
        if (exp_q.size() == 0) begin
            chk("w3_queue_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("w3_rv_h%0d", i), 32'(rv1), 32'd1);
                chk($sformatf("w3_err_h%0d", i), 32'(er1), 32'(e[2]));
                chk($sformatf("w3_idx_h%0d", i), 32'(idx1), 32'(e[1:0]));
                chk($sformatf("w3_ready_h%0d", i), 32'(cr1), 32'd0);
                chk($sformatf("w3_sel_h%0d", i), 32'(sel1), 32'd0);
                step();
            end
        end
        v1 = 1'b0; rr1 = 1'b1;
        step();
        chk("w3_rv_done", 32'(rv1), 32'd0);
        chk("w3_idle", 32'(cr1), 32'd1);
        step();
        chk("w3_no_extra", 32'(rv1), 32'd0);

        // d2: overlapping windows, lowest index wins
        a2 = 16'h0009; r2 = 1'b1; w2 = 1'b0; v2 = 1'b1; rr2 = 1'b1;
        exp_q.push_back({1'b0, 2'd0});
        step();
        v2 = 1'b0;
        chk("ov_sel_c0", 32'(sel2), 32'h1);
        step();
        chk("ov_sel_c1", 32'(sel2), 32'h1);
        step();
        chk("ov_rv", 32'(rv2), 32'd1);
        if (exp_q.size() == 0) begin
            chk("ov_queue_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk("ov_err", 32'(er2), 32'(e[2]));
            chk("ov_idx", 32'(idx2), 32'(e[1:0]));
        end
        step();
        chk("ov_idle", 32'(cr2), 32'd1);

        // d2: reset in the second ACCESS cycle drops the command
        a2 = 16'h0024; r2 = 1'b1; v2 = 1'b1;
        step();
        v2 = 1'b0;
        chk("rs_sel_c0", 32'(sel2), 32'h4);
        step();
        chk("rs_sel_c1", 32'(sel2), 32'h4);
        rst2_n = 1'b0;
        #1;
        chk("rs_sel_async", 32'(sel2), 32'd0);
        chk("rs_rd_async", 32'(or2), 32'd0);
        chk("rs_rv_async", 32'(rv2), 32'd0);
        chk("rs_ready_async", 32'(cr2), 32'd1);
        step();
        rst2_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("rs_no_resp_%0d", i), 32'(rv2), 32'd0);
            chk($sformatf("rs_sel_off_%0d", i), 32'(sel2), 32'd0);
        end
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
